pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: start-button conditioning, serve countdown, point hold and win detection.
// Define PONG_PAUSE_EN to add a PAUSE state toggled by the start button during play.
module pong_game_ctrl #(
    parameter int WIN_SCORE       = 11,
    parameter int SERVE_FRAMES    = 60,
    parameter int POINT_FRAMES    = 90,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk_pix,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       frame_tick,
    input  logic [6:0] score_left,
    input  logic [6:0] score_right,
    output logic       game_active,
    output logic       game_rst_n,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic [1:0] winner,
    output logic       paused
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SERVE = 3'd2,
        PLAY  = 3'd3,
        POINT = 3'd4,
        OVER  = 3'd5,
        PAUSE = 3'd6
    } state_t;

    localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]        SERVE_END = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]        POINT_END = 8'(POINT_FRAMES - 1);
    localparam logic [6:0]        WIN_VAL   = 7'(WIN_SCORE);

    state_t          state_q;
    state_t          state_d;
    logic            btn_meta;
    logic            btn_sync;
    logic [DB_W-1:0] db_cnt;
    logic            db_level;
    logic            press;
    logic [7:0]      frame_cnt;
    logic [6:0]      hist_left;
    logic [6:0]      hist_right;
    logic            score_changed;
    logic            left_win;
    logic            right_win;
    logic            serve_step;
    logic            point_done;

    // Button idles high, so the synchroniser resets to 1 to avoid a false edge.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
        end else begin
            btn_meta <= btn_start;
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= 1'b1;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_sync == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt   <= '0;
                db_level <= btn_sync;
                press    <= ~btn_sync;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign score_changed = (score_left != hist_left) || (score_right != hist_right);
    assign left_win      = (score_left >= WIN_VAL);
    assign right_win     = (score_right >= WIN_VAL);
    assign serve_step    = frame_tick && (frame_cnt == SERVE_END);
    assign point_done    = frame_tick && (frame_cnt == POINT_END);

    // A score change in PLAY is checked before the button so it always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (press) state_d = CLEAR;
            CLEAR: state_d = SERVE;
            SERVE: if (serve_step && (countdown == 2'd1)) state_d = PLAY;
            PLAY: begin
                if (score_changed) begin
                    state_d = (left_win || right_win) ? OVER : POINT;
                end
`ifdef PONG_PAUSE_EN
                else if (press) begin
                    state_d = PAUSE;
                end
`endif
            end
            POINT: if (point_done) state_d = SERVE;
            OVER:  if (press) state_d = CLEAR;
`ifdef PONG_PAUSE_EN
            PAUSE: if (press) state_d = PLAY;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            game_active <= 1'b0;
            game_rst_n  <= 1'b1;
        end else begin
            state_q     <= state_d;
            game_active <= (state_d == PLAY);
            game_rst_n  <= (state_d != CLEAR);
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            hist_left  <= '0;
            hist_right <= '0;
        end else if (state_q == CLEAR) begin
            hist_left  <= '0;
            hist_right <= '0;
        end else begin
            hist_left  <= score_left;
            hist_right <= score_right;
        end
    end

    // Frame counter restarts on any state change and wraps after each countdown step.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (state_d != state_q) begin
            frame_cnt <= '0;
        end else if (frame_tick && ((state_q == SERVE) || (state_q == POINT))) begin
            if ((state_q == SERVE) && serve_step) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            countdown <= 2'd0;
        end else if (state_d == CLEAR) begin
            countdown <= 2'd3;
        end else if ((state_q == SERVE) && serve_step) begin
            countdown <= countdown - 2'd1;
        end else if ((state_q == POINT) && (state_d == SERVE)) begin
            countdown <= 2'd3;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            winner <= 2'b00;
        end else if (state_d == CLEAR) begin
            winner <= 2'b00;
        end else if ((state_q == PLAY) && (state_d == OVER)) begin
            winner <= {right_win, left_win};
        end
    end

`ifdef PONG_PAUSE_EN
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            paused <= 1'b0;
        end else begin
            paused <= (state_d == PAUSE);
        end
    end
`else
    assign paused = 1'b0;
`endif

    assign state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a table of scenario steps plus hand-written
// sequences for reset, debounce glitch and press/score collisions.
module tb_pong_game_ctrl;

   localparam int WIN = 3;
   localparam int SF  = 2;
   localparam int PF  = 3;
   localparam int DB  = 4;

   localparam int S_IDLE  = 0;
   localparam int S_CLEAR = 1;
   localparam int S_SERVE = 2;
   localparam int S_PLAY  = 3;
   localparam int S_POINT = 4;
   localparam int S_OVER  = 5;
   localparam int S_PAUSE = 6;

   logic       clk_pix = 1'b0;
   logic       rst_n;
   logic       btn_start;
   logic       frame_tick;
   logic [6:0] score_left;
   logic [6:0] score_right;
   logic       game_active;
   logic       game_rst_n;
   logic [2:0] state;
   logic [1:0] countdown;
   logic [1:0] winner;
   logic       paused;

   int vec_count   = 0;
   int miscompares = 0;
   int clear_seen  = 0;
   int rst_low     = 0;
   int clear_winner_bad = 0;

   typedef struct {
      bit press;
      int frames;
      int sl;
      int sr;
      int wait_cycles;
      int exp_state;
      int exp_active;
      int exp_cd;
      int exp_winner;
      int exp_paused;
   } vec_t;

   vec_t vecs[$];

   // Free-running pixel clock
   always #5 clk_pix = ~clk_pix;

   pong_game_ctrl #(
      .WIN_SCORE(WIN),
      .SERVE_FRAMES(SF),
      .POINT_FRAMES(PF),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk_pix(clk_pix),
      .rst_n(rst_n),
      .btn_start(btn_start),
      .frame_tick(frame_tick),
      .score_left(score_left),
      .score_right(score_right),
      .game_active(game_active),
      .game_rst_n(game_rst_n),
      .state(state),
      .countdown(countdown),
      .winner(winner),
      .paused(paused)
   );

   // Cycle-level observer for short pulses the main sequence cannot easily catch
   always @(posedge clk_pix) begin
      #2;
      if (state == 3'(S_CLEAR)) begin
         clear_seen++;
         if (winner != 2'b00) clear_winner_bad++;
      end
      if (!game_rst_n) rst_low++;
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish before it");
      $fatal(1, "[TB] watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_pix);
   endtask

   task automatic pulseFrame();
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
   endtask

   task automatic pressButton();
      btn_start = 1'b0;
      cyc(8);
      btn_start = 1'b1;
      cyc(8);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input int st, input int act, input int cd, input int win, input int pau);
      checkOutput({tag, ".state"}, 32'(state), st);
      checkOutput({tag, ".game_active"}, 32'(game_active), act);
      checkOutput({tag, ".countdown"}, 32'(countdown), cd);
      checkOutput({tag, ".winner"}, 32'(winner), win);
      checkOutput({tag, ".paused"}, 32'(paused), pau);
   endtask

   task automatic applyStimulus(input vec_t v);
      score_left  = 7'(v.sl);
      score_right = 7'(v.sr);
      cyc(2);
      if (v.press) pressButton();
      for (int i = 0; i < v.frames; i++) pulseFrame();
      cyc(v.wait_cycles);
   endtask

   function automatic vec_t mk(input bit p, input int f, input int sl, input int sr,
                               input int st, input int act, input int cd, input int win, input int pau);
      vec_t v;
      v.press = p;
      v.frames = f;
      v.sl = sl;
      v.sr = sr;
      v.wait_cycles = 1;
      v.exp_state = st;
      v.exp_active = act;
      v.exp_cd = cd;
      v.exp_winner = win;
      v.exp_paused = pau;
      return v;
   endfunction

   initial begin
      int clear_before;
      int rst_before;

      // Scenario table, starting from SERVE with countdown 3 and scores 0:0
      vecs.push_back(mk(0, 2, 0, 0, S_SERVE, 0, 2, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, S_SERVE, 0, 2, 0, 0));
      vecs.push_back(mk(0, 2, 0, 0, S_SERVE, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, S_SERVE, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, S_PLAY,  1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, S_POINT, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, S_POINT, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2, 1, 0, S_POINT, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, S_SERVE, 0, 3, 0, 0));
      vecs.push_back(mk(0, 6, 1, 0, S_PLAY,  1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, S_POINT, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3, 1, 1, S_SERVE, 0, 3, 0, 0));
      vecs.push_back(mk(0, 6, 1, 1, S_PLAY,  1, 0, 0, 0));
`ifdef PONG_PAUSE_EN
      vecs.push_back(mk(1, 0, 1, 1, S_PAUSE, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 2, 2, S_PAUSE, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 2, 2, S_PLAY,  1, 0, 0, 0));
`else
      vecs.push_back(mk(1, 0, 1, 1, S_PLAY,  1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 2, 2, S_POINT, 0, 0, 0, 0));
      vecs.push_back(mk(0, 9, 2, 2, S_PLAY,  1, 0, 0, 0));
`endif
      vecs.push_back(mk(0, 0, 2, 3, S_OVER,  0, 0, 2, 0));
      vecs.push_back(mk(0, 2, 2, 3, S_OVER,  0, 0, 2, 0));
      vecs.push_back(mk(1, 0, 0, 0, S_SERVE, 0, 3, 0, 0));
      vecs.push_back(mk(0, 6, 0, 0, S_PLAY,  1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 3, 3, S_OVER,  0, 0, 3, 0));
      vecs.push_back(mk(1, 6, 0, 0, S_PLAY,  1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 3, 0, S_OVER,  0, 0, 1, 0));
      vecs.push_back(mk(1, 6, 0, 0, S_PLAY,  1, 0, 0, 0));

      // Reset with the button already held down
      rst_n       = 1'b0;
      btn_start   = 1'b0;
      frame_tick  = 1'b0;
      score_left  = 7'd0;
      score_right = 7'd0;
      cyc(3);
      checkAll("reset", S_IDLE, 0, 0, 0, 0);
      checkOutput("reset.game_rst_n", 32'(game_rst_n), 1);

      rst_n = 1'b1;
      cyc(5);
      checkOutput("early_no_press.state", 32'(state), S_IDLE);
      cyc(5);
      checkOutput("first_press.state", 32'(state), S_SERVE);
      checkOutput("first_press.countdown", 32'(countdown), 3);
      checkOutput("first_press.clear_cycles", 32'(clear_seen), 1);
      checkOutput("first_press.rst_low_cycles", 32'(rst_low), 1);
      btn_start = 1'b1;
      cyc(8);
      checkOutput("single_press.clear_cycles", 32'(clear_seen), 1);
      checkOutput("single_press.state", 32'(state), S_SERVE);

      // Table-driven scenario
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkAll($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_active,
                  vecs[i].exp_cd, vecs[i].exp_winner, vecs[i].exp_paused);
      end
      checkOutput("clear_winner_zero", 32'(clear_winner_bad), 0);

      // Press and score change land in the same cycle during PLAY
      btn_start = 1'b0;
      cyc(6);
      score_left = 7'd1;
      cyc(2);
      checkOutput("collide.state", 32'(state), S_POINT);
      checkOutput("collide.paused", 32'(paused), 0);
      btn_start = 1'b1;
      cyc(8);
      checkOutput("collide_after.state", 32'(state), S_POINT);

      // Asynchronous reset in the middle of a serve countdown
      for (int i = 0; i < 3; i++) pulseFrame();
      pulseFrame();
      checkOutput("pre_reset.state", 32'(state), S_SERVE);
      checkOutput("pre_reset.countdown", 32'(countdown), 3);
      #2 rst_n = 1'b0;
      #1;
      checkAll("async_reset", S_IDLE, 0, 0, 0, 0);
      checkOutput("async_reset.game_rst_n", 32'(game_rst_n), 1);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      checkOutput("post_reset.state", 32'(state), S_IDLE);

      // Three-cycle glitch must not register as a press
      clear_before = clear_seen;
      btn_start = 1'b0;
      cyc(3);
      btn_start = 1'b1;
      cyc(12);
      checkOutput("glitch.state", 32'(state), S_IDLE);
      checkOutput("glitch.clear_cycles", 32'(clear_seen - clear_before), 0);

      // A genuine press still starts a match afterwards
      rst_before = rst_low;
      pressButton();
      checkOutput("restart.state", 32'(state), S_SERVE);
      checkOutput("restart.countdown", 32'(countdown), 3);
      checkOutput("restart.clear_cycles", 32'(clear_seen - clear_before), 1);
      checkOutput("restart.rst_low_cycles", 32'(rst_low - rst_before), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
